// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  // EX operand source select.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_t;

  // Multicycle execute sequencer states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ex_state_t;

  // Bit positions of each stage in the valid vector.
  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// Forwarding source select for one EX operand: M beats W, x0 never forwards.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_regwrite,
  input  logic              m_valid,
  input  logic [REG_AW-1:0] w_rd,
  input  logic              w_regwrite,
  input  logic              w_valid,
  output fwd_sel_t          sel
);

  // Youngest matching producer wins.
  always_comb begin
    sel = FWD_NONE;
    if (src != '0) begin
      if (m_regwrite && m_valid && (m_rd == src)) begin
        sel = FWD_M;
      end else if (w_regwrite && w_valid && (w_rd == src)) begin
        sel = FWD_W;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: stalls, flushes, forwarding and
// per-stage valid tracking, including a multicycle execute sequencer.
//
// Handshake: there is no valid/ready pair here; a stage advances on a cycle
// when its stall output is low, and a flush output replaces the register
// contents with a bubble on that same edge.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int EX_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic [REG_AW-1:0] e_rs1,
  input  logic [REG_AW-1:0] e_rs2,
  input  logic [REG_AW-1:0] e_rd,
  input  logic [REG_AW-1:0] m_rd,
  input  logic [REG_AW-1:0] w_rd,
  input  logic              d_use1,
  input  logic              d_use2,
  input  logic              e_regwrite,
  input  logic              e_memread,
  input  logic              e_multicycle,
  input  logic              e_b_taken,
  input  logic              m_regwrite,
  input  logic              w_regwrite,
  input  logic              mem_d_stall,
  output logic              f_stall,
  output logic              d_stall,
  output logic              e_stall,
  output logic              m_stall,
  output logic              d_flush,
  output logic              e_flush,
  output fwd_sel_t          fwd_a,
  output fwd_sel_t          fwd_b,
  output logic [4:0]        valid,
  output logic              ex_busy,
  output ex_state_t         dbg_state
);

  localparam int              CW       = $clog2(EX_LAT + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(EX_LAT - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [4:0]    valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ex_state_t     state_q, state_d;

  logic     mc_start, ex_hold, br_taken, load_use;
  fwd_sel_t fwd_a_raw, fwd_b_raw;

  // The destination-write qualifier of EX does not influence any hazard here.
  logic unused_inputs;
  assign unused_inputs = e_regwrite;

  // Hazard terms from current inputs and state.
  always_comb begin
    mc_start = (state_q == IDLE) && valid_q[STG_E] && e_multicycle && (EX_LAT > 1);
    // The start cycle holds EX; in BUSY the hold lasts until the count is 1,
    // on which cycle EX is released, giving EX_LAT cycles of occupancy.
    ex_hold  = mc_start || ((state_q == BUSY) && (cnt_q > CNT_ONE));
    br_taken = valid_q[STG_E] && e_b_taken;
    load_use = valid_q[STG_E] && e_memread && (e_rd != '0) &&
               ((d_use1 && (d_rs1 == e_rd)) || (d_use2 && (d_rs2 == e_rd)));
  end

  // Priority: memory stall > multicycle hold > branch flush > load-use.
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    f_stall = 1'b0;
    d_stall = 1'b0;
    e_stall = 1'b0;
    m_stall = 1'b0;
    d_flush = 1'b0;
    e_flush = 1'b0;
    ex_busy = 1'b0;
    if (mem_d_stall) begin
      f_stall = 1'b1;
      d_stall = 1'b1;
      e_stall = 1'b1;
      m_stall = 1'b1;
    end else if (ex_hold) begin
      f_stall = 1'b1;
      d_stall = 1'b1;
      e_stall = 1'b1;
      ex_busy = 1'b1;
      // M drains into W while a bubble enters M.
      valid_d = {valid_q[STG_M], 1'b0, valid_q[STG_E:STG_F]};
      if (mc_start) begin
        cnt_d   = CNT_LOAD;
        state_d = BUSY;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      if (state_q == BUSY) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      if (br_taken) begin
        d_flush = 1'b1;
        e_flush = 1'b1;
        valid_d = {valid_q[STG_M], valid_q[STG_E], 2'b00, 1'b1};
      end else if (load_use) begin
        f_stall = 1'b1;
        d_stall = 1'b1;
        valid_d = {valid_q[STG_M], valid_q[STG_E], 1'b0, valid_q[STG_D], valid_q[STG_F]};
      end else begin
        valid_d = {valid_q[STG_M:STG_F], 1'b1};
      end
    end
    if (reset) begin
      f_stall = 1'b0;
      d_stall = 1'b0;
      e_stall = 1'b0;
      m_stall = 1'b0;
      d_flush = 1'b0;
      e_flush = 1'b0;
      ex_busy = 1'b0;
    end
  end

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .src       (e_rs1),
    .m_rd      (m_rd),
    .m_regwrite(m_regwrite),
    .m_valid   (valid_q[STG_M]),
    .w_rd      (w_rd),
    .w_regwrite(w_regwrite),
    .w_valid   (valid_q[STG_W]),
    .sel       (fwd_a_raw)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .src       (e_rs2),
    .m_rd      (m_rd),
    .m_regwrite(m_regwrite),
    .m_valid   (valid_q[STG_M]),
    .w_rd      (w_rd),
    .w_regwrite(w_regwrite),
    .w_valid   (valid_q[STG_W]),
    .sel       (fwd_b_raw)
  );

  // Forwarding selects are forced to no-forward while reset is held.
  always_comb begin
    fwd_a = reset ? FWD_NONE : fwd_a_raw;
    fwd_b = reset ? FWD_NONE : fwd_b_raw;
  end

  // State registers; reset aborts any multicycle op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign valid     = valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  localparam int AW = 5;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd;
  logic d_use1, d_use2, e_regwrite, e_memread, e_multicycle, e_b_taken;
  logic m_regwrite, w_regwrite, mem_d_stall;

  logic f_stall, d_stall, e_stall, m_stall, d_flush, e_flush, ex_busy;
  fwd_sel_t fwd_a, fwd_b;
  logic [4:0] valid;
  ex_state_t dbg_state;

  logic l1_f_stall, l1_d_stall, l1_e_stall, l1_m_stall, l1_d_flush, l1_e_flush, l1_ex_busy;
  fwd_sel_t l1_fwd_a, l1_fwd_b;
  logic [4:0] l1_valid;
  ex_state_t l1_dbg_state;

  pipe_ctrl #(.REG_AW(AW), .EX_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .e_rs1(e_rs1), .e_rs2(e_rs2),
    .e_rd(e_rd), .m_rd(m_rd), .w_rd(w_rd),
    .d_use1(d_use1), .d_use2(d_use2), .e_regwrite(e_regwrite),
    .e_memread(e_memread), .e_multicycle(e_multicycle), .e_b_taken(e_b_taken),
    .m_regwrite(m_regwrite), .w_regwrite(w_regwrite), .mem_d_stall(mem_d_stall),
    .f_stall(f_stall), .d_stall(d_stall), .e_stall(e_stall), .m_stall(m_stall),
    .d_flush(d_flush), .e_flush(e_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .valid(valid), .ex_busy(ex_busy), .dbg_state(dbg_state)
  );

  pipe_ctrl #(.REG_AW(AW), .EX_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .e_rs1(e_rs1), .e_rs2(e_rs2),
    .e_rd(e_rd), .m_rd(m_rd), .w_rd(w_rd),
    .d_use1(d_use1), .d_use2(d_use2), .e_regwrite(e_regwrite),
    .e_memread(e_memread), .e_multicycle(e_multicycle), .e_b_taken(e_b_taken),
    .m_regwrite(m_regwrite), .w_regwrite(w_regwrite), .mem_d_stall(mem_d_stall),
    .f_stall(l1_f_stall), .d_stall(l1_d_stall), .e_stall(l1_e_stall), .m_stall(l1_m_stall),
    .d_flush(l1_d_flush), .e_flush(l1_e_flush), .fwd_a(l1_fwd_a), .fwd_b(l1_fwd_b),
    .valid(l1_valid), .ex_busy(l1_ex_busy), .dbg_state(l1_dbg_state)
  );

  // Scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    d_rs1 = '0; d_rs2 = '0; e_rs1 = '0; e_rs2 = '0;
    e_rd = '0; m_rd = '0; w_rd = '0;
    d_use1 = 1'b0; d_use2 = 1'b0; e_regwrite = 1'b0; e_memread = 1'b0;
    e_multicycle = 1'b0; e_b_taken = 1'b0;
    m_regwrite = 1'b0; w_regwrite = 1'b0; mem_d_stall = 1'b0;
  endtask

  task automatic refill();
    clear_inputs();
    repeat (5) step();
    check_eq("refill_valid", valid, 5'b11111);
  endtask

  task automatic set_load_use();
    e_memread = 1'b1; e_regwrite = 1'b1; e_rd = 5'd5;
    d_rs1 = 5'd5; d_use1 = 1'b1;
  endtask

  logic [7:0] exp;

  initial begin
    clear_inputs();
    // Reset state, with inputs that would otherwise stall and forward.
    reset = 1'b1;
    mem_d_stall = 1'b1;
    m_regwrite = 1'b1; m_rd = 5'd3; e_rs1 = 5'd3;
    step();
    step();
    settle();
    check_eq("rst_valid", valid, 5'b00000);
    check_eq("rst_stalls", {f_stall, d_stall, e_stall, m_stall}, 4'b0000);
    check_eq("rst_flush", {d_flush, e_flush}, 2'b00);
    check_eq("rst_busy", ex_busy, 1'b0);
    check_eq("rst_fwd_a", fwd_a, FWD_NONE);
    check_eq("rst_state", dbg_state, IDLE);

    reset = 1'b0;
    clear_inputs();
    step();
    check_eq("post_rst_valid0", valid, 5'b00001);
    repeat (4) step();
    check_eq("fill_valid", valid, 5'b11111);

    // Forwarding priority vectors.
    m_regwrite = 1'b1; w_regwrite = 1'b1; m_rd = 5'd7; w_rd = 5'd7; e_rs2 = 5'd7; e_rs1 = 5'd3;
    settle();
    check_eq("fwd_b_m_over_w", fwd_b, FWD_M);
    check_eq("fwd_a_nomatch", fwd_a, FWD_NONE);
    m_regwrite = 1'b0;
    settle();
    check_eq("fwd_b_w_only", fwd_b, FWD_W);
    clear_inputs();
    m_regwrite = 1'b1; m_rd = 5'd0; e_rs1 = 5'd0; w_regwrite = 1'b1; w_rd = 5'd0;
    settle();
    check_eq("fwd_a_x0", fwd_a, FWD_NONE);
    clear_inputs();

    // x0 as load destination never stalls.
    e_memread = 1'b1; e_rd = 5'd0; d_rs1 = 5'd0; d_use1 = 1'b1;
    settle();
    check_eq("lu_x0_stalls", {f_stall, d_stall, e_stall, m_stall}, 4'b0000);
    clear_inputs();

    // Load-use: one stall cycle, bubble into EX, then W forwarding.
    set_load_use();
    settle();
    check_eq("lu_stalls", {f_stall, d_stall, e_stall, m_stall}, 4'b1100);
    check_eq("lu_flush", {d_flush, e_flush}, 2'b00);
    step();
    check_eq("lu_bubble_valid", valid, 5'b11011);
    settle();
    check_eq("lu_stall_one_cycle", {f_stall, d_stall}, 2'b00);
    step();
    check_eq("lu_consumer_valid", valid, 5'b10111);
    clear_inputs();
    e_rs1 = 5'd5; w_rd = 5'd5; w_regwrite = 1'b1; m_rd = 5'd5; m_regwrite = 1'b1;
    settle();
    check_eq("lu_fwd_a_w", fwd_a, FWD_W);

    // Memory stall during a taken branch.
    refill();
    set_load_use();
    settle();
    step();
    clear_inputs();
    step();
    check_eq("ms_pre_valid", valid, 5'b10111);
    e_b_taken = 1'b1; mem_d_stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      check_eq("ms_stalls", {f_stall, d_stall, e_stall, m_stall}, 4'b1111);
      check_eq("ms_no_flush", {d_flush, e_flush}, 2'b00);
      step();
      check_eq("ms_frozen_valid", valid, 5'b10111);
    end
    mem_d_stall = 1'b0;
    settle();
    check_eq("ms_flush_fires", {d_flush, e_flush}, 2'b11);
    check_eq("ms_release_stalls", {f_stall, d_stall, e_stall, m_stall}, 4'b0000);
    step();
    check_eq("ms_flush_valid", valid, 5'b01001);

    // Taken branch together with load-use: flush wins.
    refill();
    set_load_use();
    e_b_taken = 1'b1;
    settle();
    check_eq("bl_flush", {d_flush, e_flush}, 2'b11);
    check_eq("bl_stalls", {f_stall, d_stall, e_stall, m_stall}, 4'b0000);
    step();
    check_eq("bl_valid", valid, 5'b11001);

    // Multicycle op, EX_LAT=4: {ex_busy, e_stall, f_stall, valid} per cycle.
    refill();
    exp_q.push_back({3'b111, 5'b11111});
    exp_q.push_back({3'b111, 5'b10111});
    exp_q.push_back({3'b111, 5'b00111});
    exp_q.push_back({3'b000, 5'b00111});
    for (int c = 0; c < 4; c++) begin
      e_multicycle = 1'b1;
      settle();
      exp = exp_q.pop_front();
      check_eq("mc_cycle", {ex_busy, e_stall, f_stall, valid}, exp);
      if (c == 0) begin
        check_eq("mc_start_state", dbg_state, IDLE);
        check_eq("l1_no_stall", {l1_ex_busy, l1_e_stall, l1_f_stall}, 3'b000);
      end
      if (c == 1) begin
        check_eq("mc_busy_state", dbg_state, BUSY);
        check_eq("l1_valid_adv", l1_valid, 5'b11111);
      end
      step();
    end
    clear_inputs();
    settle();
    check_eq("mc_end_state", dbg_state, IDLE);
    check_eq("mc_end_valid", valid, 5'b01111);
    check_eq("mc_end_busy", ex_busy, 1'b0);
    check_eq("mc_queue_empty", exp_q.size(), 0);

    // Reset on the second BUSY cycle.
    refill();
    e_multicycle = 1'b1;
    settle();
    step();
    step();
    settle();
    check_eq("rb_busy_before", {ex_busy, dbg_state}, {1'b1, BUSY});
    reset = 1'b1;
    settle();
    check_eq("rb_outputs_in_reset", {f_stall, d_stall, e_stall, m_stall, ex_busy}, 5'b00000);
    step();
    reset = 1'b0;
    settle();
    check_eq("rb_busy", ex_busy, 1'b0);
    check_eq("rb_valid", valid, 5'b00000);
    check_eq("rb_state", dbg_state, IDLE);
    check_eq("rb_stalls", {f_stall, d_stall, e_stall, m_stall}, 4'b0000);
    check_eq("rb_flush", {d_flush, e_flush}, 2'b00);
    check_eq("rb_fwd", {fwd_a, fwd_b}, {FWD_NONE, FWD_NONE});
    step();
    check_eq("rb_valid0", valid, 5'b00001);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
